// File: rtl/wb_pkg.sv
// Shared definitions for the PWM register-bank Wishbone host master:
// FSM state encoding and register offsets of the PWM bank.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [15:0] CTRL    = 16'h0000;
    localparam logic [15:0] DIVISOR = 16'h0002;
    localparam logic [15:0] PERIOD  = 16'h0004;
    localparam logic [15:0] DC      = 16'h0006;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts bus cycles spent waiting for ack; expired flags the last allowed
// cycle so the master can abort in that same cycle.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: host valid/ready request in,
// one cyc/stb cycle out, read data or error back on a valid/ready response.
module wb_host_master
    import wb_pkg::*;
#(
    parameter int ADR_W   = 16,
    parameter int DAT_W   = 16,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [ADR_W-1:0] i_req_adr,
    input  logic [DAT_W-1:0] i_req_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [DAT_W-1:0] o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [DAT_W-1:0] o_wb_data,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    input  logic [DAT_W-1:0] i_wb_data
);

    wb_state_t state, state_nxt;

    logic accept;
    logic done_ack;
    logic done_err;
    logic rsp_take;
    logic cnt_clr;
    logic cnt_en;
    logic to_expired;
    logic wb_cyc;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .expired  (to_expired)
    );

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ack outranks err, err outranks timeout; ack/err outside BUS never reach here
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ack  = 1'b0;
        done_err  = 1'b0;
        rsp_take  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    accept    = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    done_ack  = 1'b1;
                    state_nxt = RESP;
                end else if (i_wb_err || to_expired) begin
                    done_err  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            wb_cyc      <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_data   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wb_cyc    <= 1'b1;
                o_wb_we   <= i_req_we;
                o_wb_adr  <= i_req_adr;
                o_wb_data <= i_req_data;
            end
            if (done_ack || done_err) begin
                wb_cyc      <= 1'b0;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= done_err;
                o_rsp_data  <= (done_ack && !o_wb_we) ? i_wb_data : '0;
            end
            if (rsp_take) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_wb_cyc    = wb_cyc;
    assign o_wb_stb    = wb_cyc;
    assign o_req_ready = (state == IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a small behavioural Wishbone slave
// whose ack/err behaviour is switched per test.
module tb_wb_host_master;

    localparam int ADR_W   = 16;
    localparam int DAT_W   = 16;
    localparam int TIMEOUT = 16;

    localparam int M_REG    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_BOTH   = 2;
    localparam int M_STICKY = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [ADR_W-1:0] req_adr = '0;
    logic [DAT_W-1:0] req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [DAT_W-1:0] rsp_data;
    logic             rsp_err;
    logic             wb_cyc, wb_stb, wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_wdata;
    logic             wb_ack = 1'b0;
    logic             wb_err = 1'b0;
    logic [DAT_W-1:0] wb_rdata;

    logic [DAT_W-1:0] mem [16];
    int               mode = M_REG;

    int n_cmp = 0;
    int n_bad = 0;

    wb_host_master #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_wb_clk    (clk),
        .i_wb_rst    (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_adr   (req_adr),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_adr    (wb_adr),
        .o_wb_data   (wb_wdata),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err),
        .i_wb_data   (wb_rdata)
    );

    always #5 clk = ~clk;

    // Slave: combinational read data, ack/err pattern chosen by mode
    always_comb wb_rdata = mem[wb_adr[3:0]];

    always @(posedge clk) begin
        if (wb_stb && wb_we && wb_ack)
            mem[wb_adr[3:0]] <= wb_wdata;
        case (mode)
            M_REG:    begin wb_ack <= wb_stb && !wb_ack; wb_err <= 1'b0; end
            M_NOACK:  begin wb_ack <= 1'b0;              wb_err <= 1'b0; end
            M_BOTH:   begin wb_ack <= wb_stb && !wb_ack; wb_err <= wb_stb && !wb_ack; end
            default:  begin wb_ack <= 1'b1;              wb_err <= 1'b0; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DAT_W-1:0] x_data;
    logic             x_err;
    logic             x_cyc;
    int               x_lat, x_stb, x_bad;

    // Called at a negedge in IDLE; returns at the negedge where rsp_valid is seen.
    task automatic run_xfer(input logic we, input logic [ADR_W-1:0] adr, input logic [DAT_W-1:0] dat);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_data  = dat;
        @(negedge clk);
        req_valid = 1'b0;
        x_lat = 1;
        x_stb = 0;
        x_bad = 0;
        while (!rsp_valid && x_lat < 200) begin
            if (wb_stb) begin
                x_stb++;
                if (wb_we !== we || wb_adr !== adr || (we && wb_wdata !== dat) || wb_cyc !== 1'b1)
                    x_bad++;
            end
            if (req_ready) x_bad++;
            @(negedge clk);
            x_lat++;
        end
        x_data = rsp_data;
        x_err  = rsp_err;
        x_cyc  = wb_cyc;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int bad;
        logic [DAT_W-1:0] held;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 16'hA5A5;
        mem[6] = 16'h00FF;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_cyc", wb_cyc, 0);
        check_eq("rst_stb", wb_stb, 0);
        check_eq("rst_we", wb_we, 0);
        check_eq("rst_adr", wb_adr, 0);
        check_eq("rst_wdata", wb_wdata, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x1234 to PERIOD with a registered-ack slave
        run_xfer(1'b1, wb_pkg::PERIOD, 16'h1234);
        check_eq("wr_latency", x_lat, 3);
        check_eq("wr_stb_cycles", x_stb, 2);
        check_eq("wr_stable", x_bad, 0);
        check_eq("wr_err", x_err, 0);
        check_eq("wr_data", x_data, 16'h0000);
        consume();
        check_eq("wr_ready_back", req_ready, 1);

        run_xfer(1'b0, wb_pkg::PERIOD, 16'h0000);
        check_eq("rb_latency", x_lat, 3);
        check_eq("rb_data", x_data, 16'h1234);
        check_eq("rb_err", x_err, 0);
        consume();

        run_xfer(1'b0, wb_pkg::DC, 16'h0000);
        check_eq("rd_dc_data", x_data, 16'h00FF);
        check_eq("rd_dc_err", x_err, 0);
        check_eq("rd_cyc_after_ack", x_cyc, 0);
        consume();

        // No ack: abort after exactly TIMEOUT stb cycles
        mode = M_NOACK;
        run_xfer(1'b0, wb_pkg::DIVISOR, 16'h0000);
        check_eq("to_stb_cycles", x_stb, TIMEOUT);
        check_eq("to_latency", x_lat, TIMEOUT + 1);
        check_eq("to_err", x_err, 1);
        check_eq("to_data", x_data, 16'h0000);
        check_eq("to_cyc", x_cyc, 0);
        consume();

        // Ack and err together: ack wins
        mode = M_BOTH;
        run_xfer(1'b0, wb_pkg::CTRL, 16'h0000);
        check_eq("both_err", x_err, 0);
        check_eq("both_data", x_data, 16'hA5A5);
        check_eq("both_latency", x_lat, 3);
        consume();

        // Sticky ack held in IDLE is ignored
        mode = M_STICKY;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_cyc || rsp_valid || !req_ready) bad++;
        end
        check_eq("sticky_idle_quiet", bad, 0);
        run_xfer(1'b0, wb_pkg::DC, 16'h0000);
        check_eq("sticky_latency", x_lat, 2);
        check_eq("sticky_stb_cycles", x_stb, 1);
        check_eq("sticky_data", x_data, 16'h00FF);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!rsp_valid || wb_cyc || rsp_data !== 16'h00FF || rsp_err) bad++;
        end
        check_eq("sticky_resp_hold", bad, 0);
        mode = M_REG;
        consume();
        run_xfer(1'b1, wb_pkg::DIVISOR, 16'h0BEE);
        check_eq("post_sticky_stb", x_stb, 2);
        check_eq("post_sticky_latency", x_lat, 3);
        consume();

        // Backpressure on the response port
        run_xfer(1'b0, wb_pkg::DIVISOR, 16'h0000);
        check_eq("bp_data", x_data, 16'h0BEE);
        held = rsp_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || rsp_err || req_ready || wb_cyc) bad++;
        end
        check_eq("bp_hold", bad, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = wb_pkg::PERIOD;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_rel_cyc1", wb_cyc, 0);
        check_eq("bp_rel_ready1", req_ready, 1);
        check_eq("bp_rel_valid1", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("bp_rel_cyc2", wb_cyc, 1);
        bad = 0;
        while (!rsp_valid && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        check_eq("bp_next_data", rsp_data, 16'h1234);
        consume();

        // Asynchronous reset in mid-BUS
        mode = M_NOACK;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = wb_pkg::CTRL;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_bus_cyc", wb_cyc, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_cyc", wb_cyc, 0);
        check_eq("arst_stb", wb_stb, 0);
        check_eq("arst_rsp_valid", rsp_valid, 0);
        check_eq("arst_req_ready", req_ready, 1);
        @(negedge clk);
        rst  = 1'b0;
        mode = M_REG;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc || !req_ready) bad++;
        end
        check_eq("arst_no_stale", bad, 0);
        run_xfer(1'b0, wb_pkg::DC, 16'h0000);
        check_eq("arst_after_data", x_data, 16'h00FF);
        check_eq("arst_after_latency", x_lat, 3);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer initiator for the PWM register bank. It accepts one read or write request at a time from a host-side command port, such as the UART command decoder, through a valid/ready handshake. It runs the matching cyc/stb cycle against the Wishbone slave interface and returns the read data or an error flag on a valid/ready response port. A cycle counter aborts any transfer the slave never acknowledges.

## Interface
- ADR_W, 16: Wishbone address width.
- DAT_W, 16: Wishbone data width.
- TIMEOUT, 16: maximum number of cycles stb is held high without ack before the transfer is aborted. Must be ≥ 2.
- TO_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- i_wb_clk  in  1  system clock; all logic on its rising edge.
- i_wb_rst  in  1  reset i_wb_rst, asynchronous, active-high; clock i_wb_clk.
- i_req_valid  in  1  host request present.
- o_req_ready  out  1  master can accept a request; high exactly in IDLE.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_adr  in  ADR_W  target register address.
- i_req_data  in  DAT_W  write data; ignored for reads.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  host consumes the response.
- o_rsp_data  out  DAT_W  read data; 0x0000 for writes and errors.
- o_rsp_err  out  1  1 = timeout or bus error.
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle and strobe; always equal.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_adr  out  ADR_W  Wishbone address.
- o_wb_data  out  DAT_W  Wishbone write data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_err  in  1  slave error; tie 0 if the slave has none.
- i_wb_data  in  DAT_W  slave read data.

## Operation
- States: IDLE, BUS, RESP. Reset enters IDLE.
- Reset values:
  - cyc, stb, we, adr, wb data, rsp_valid, rsp_data and rsp_err are all 0.
  - o_req_ready is 1, since it is decoded from state.
- IDLE:
  - When i_req_valid and o_req_ready are both high, register we, adr and data onto the wb outputs.
  - Set cyc/stb, clear the timeout counter and go to BUS.
- BUS: cyc/stb held high; wb outputs stay stable.
  - Ack sampled: capture rsp_data (i_wb_data if read, else 0), set rsp_err = 0, drop cyc/stb, go to RESP.
  - Err sampled, with no ack: set rsp_data = 0 and rsp_err = 1, drop cyc/stb, go to RESP.
  - Neither sampled: increment the counter. When the counter reaches TIMEOUT-1 with no ack, treat it as err.
  - Priority when several occur in the same cycle: ack > err > timeout.
- RESP:
  - o_rsp_valid is high and the response is held stable until i_rsp_ready is sampled high.
  - Then clear rsp_valid and go to IDLE.
- Ack or err arriving outside BUS (a stale or sticky ack) is ignored.
- Only one transfer is ever outstanding. No pipelining and no burst.
- Reset during BUS or RESP: cyc/stb and rsp_valid drop immediately (asynchronously); the transfer is lost without a response.

## Timing
- Cycle k: request accepted.
- Cycles k+1 onward: cyc/stb high.
- Cycle j: ack sampled.
  - cyc/stb low in cycle j+1.
  - rsp_valid high from cycle j+1.
- With a registered-ack slave (ack one cycle after stb), j = k+2. Request to response is 3 cycles, and stb is high for 2 cycles.
- Minimum gap with cyc low between back-to-back transfers is 2 cycles (RESP, then IDLE), which guarantees the slave sees stb fall.
- Timeout with no ack: stb is high for exactly TIMEOUT cycles, then rsp_valid/err.
- o_req_ready is low from the cycle after acceptance until IDLE is re-entered.

## Structure
- Shared package wb_pkg (Verilog include of localparams):
  - state encodings IDLE=2'd0, BUS=2'd1, RESP=2'd2;
  - register offsets CTRL=0, DIVISOR=2, PERIOD=4, DC=6.
- Optional sub-module wb_timeout_cnt (clear, enable, expired output, parameter TIMEOUT). The FSM and datapath stay in wb_host_master.

## Test plan
- Write 0x1234 to 0x0004, slave acks the cycle after stb:
  - wb shows we=1, adr=0x0004, data=0x1234 for 2 cycles;
  - rsp_valid 3 cycles after accept with err=0 and data=0x0000;
  - a read-back of 0x0004 returns 0x1234.
- Read 0x0006 with the slave returning 0x00FF:
  - rsp_data=0x00FF, err=0;
  - cyc low the cycle after ack.
- No ack, TIMEOUT=16: stb high exactly 16 cycles, then rsp_err=1 and rsp_data=0x0000.
- Ack and err in the same cycle: err=0 and data captured. A sticky ack held high in IDLE and RESP is ignored, and the next request still runs a full stb phase.
- Backpressure: hold i_rsp_ready=0 for 10 cycles.
  - rsp stays stable, req_ready=0 and cyc=0 throughout;
  - release it, and the next request is accepted 2 cycles later.
- Assert i_wb_rst in mid-BUS: cyc/stb/rsp_valid go to 0 without waiting for a clock edge. After release, o_req_ready=1 and no stale response is issued.
